// File: rtl/apurador_votos.sv
// Day-vote sequencer: polls each living player for one vote target, tallies
// votes per target, then scans the tally for a unique most-voted player.
//
// state        | meaning
// OCIOSO       | idle, waiting for iniciar
// ZERA         | clear tally, voter index and results
// SELECIONA    | decide whether the current player may vote
// AGUARDA_VOTO | wait for a valid vote strobe from the current player
// REGISTRA     | add the captured vote to the tally
// PROXIMO      | advance to the next player or start the scan
// APURA        | scan one tally entry per cycle for the maximum
// RESULTADO    | results latched, votou high until iniciar drops
module apurador_votos #(
  parameter int N_JOGADORES = 5,
  parameter int W_IDX       = 3,
  parameter int W_CNT       = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iniciar,
  input  logic [N_JOGADORES-1:0] vivos,
  input  logic                   voto_valido,
  input  logic [W_IDX-1:0]       voto_alvo,
  input  logic [W_IDX-1:0]       lobo_idx,
  output logic [W_IDX-1:0]       jogador_atual,
  output logic                   aguardando_voto,
  output logic                   voto_rejeitado,
  output logic                   votou,
  output logic                   acertou,
  output logic                   empate,
  output logic [W_IDX-1:0]       eliminado_idx,
  output logic [2:0]             db_estado
);

  localparam int NP = 2 ** W_IDX;
  localparam logic [W_IDX-1:0] ULTIMO = W_IDX'(N_JOGADORES - 1);

  typedef enum logic [2:0] {
    OCIOSO       = 3'd0,
    ZERA         = 3'd1,
    SELECIONA    = 3'd2,
    AGUARDA_VOTO = 3'd3,
    REGISTRA     = 3'd4,
    PROXIMO      = 3'd5,
    APURA        = 3'd6,
    RESULTADO    = 3'd7
  } estado_t;

  estado_t estado, proximo;

  // The tally is sized to the full index range so any index is in bounds;
  // entries at or above N_JOGADORES are never incremented.
  logic [W_CNT-1:0] contagem [NP];
  logic [NP-1:0]    vivos_ext;
  logic [W_IDX-1:0] alvo_reg;
  logic [W_IDX-1:0] k_idx;
  logic [W_CNT-1:0] max_reg, max_n;
  logic [W_IDX-1:0] cand_reg, cand_n;
  logic             tie_reg, tie_n, empate_n;
  logic             voto_ok;
  logic             aborta;

  assign vivos_ext = NP'(vivos);
  assign voto_ok   = (voto_alvo <= ULTIMO) && vivos_ext[voto_alvo];
  assign aborta    = !iniciar && (estado != OCIOSO) && (estado != RESULTADO);

  assign aguardando_voto = (estado == AGUARDA_VOTO);
  assign votou           = (estado == RESULTADO);
  assign db_estado       = estado;

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= OCIOSO;
    else       estado <= proximo;
  end

  // next-state and rejection pulse; a dropped iniciar overrides everything
  always_comb begin
    proximo        = estado;
    voto_rejeitado = 1'b0;
    case (estado)
      OCIOSO:       if (iniciar) proximo = ZERA;
      ZERA:         proximo = SELECIONA;
      SELECIONA:    proximo = vivos_ext[jogador_atual] ? AGUARDA_VOTO : PROXIMO;
      AGUARDA_VOTO: if (voto_valido) begin
                      if (voto_ok) proximo = REGISTRA;
                      else         voto_rejeitado = 1'b1;
                    end
      REGISTRA:     proximo = PROXIMO;
      PROXIMO:      proximo = (jogador_atual == ULTIMO) ? APURA : SELECIONA;
      APURA:        if (k_idx == ULTIMO) proximo = RESULTADO;
      RESULTADO:    if (!iniciar) proximo = OCIOSO;
      default:      proximo = OCIOSO;
    endcase
    if (aborta) begin
      proximo        = OCIOSO;
      voto_rejeitado = 1'b0;
    end
  end

  // running maximum including the tally entry under scan this cycle
  always_comb begin
    max_n  = max_reg;
    cand_n = cand_reg;
    tie_n  = tie_reg;
    if (contagem[k_idx] > max_reg) begin
      max_n  = contagem[k_idx];
      cand_n = k_idx;
      tie_n  = 1'b0;
    end else if ((contagem[k_idx] == max_reg) && (max_reg != '0)) begin
      tie_n = 1'b1;
    end
    empate_n = tie_n || (max_n == '0);
  end

  // datapath: tally, voter index, scan registers and latched results
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NP; i++) contagem[i] <= '0;
      jogador_atual <= '0;
      alvo_reg      <= '0;
      k_idx         <= '0;
      max_reg       <= '0;
      cand_reg      <= '0;
      tie_reg       <= 1'b0;
      acertou       <= 1'b0;
      empate        <= 1'b0;
      eliminado_idx <= '0;
    end else if (!aborta) begin
      case (estado)
        ZERA: begin
          for (int i = 0; i < NP; i++) contagem[i] <= '0;
          jogador_atual <= '0;
          acertou       <= 1'b0;
          empate        <= 1'b0;
          eliminado_idx <= '0;
        end
        AGUARDA_VOTO: if (voto_valido) alvo_reg <= voto_alvo;
        REGISTRA:     contagem[alvo_reg] <= contagem[alvo_reg] + W_CNT'(1);
        PROXIMO: begin
          if (jogador_atual == ULTIMO) begin
            k_idx    <= '0;
            max_reg  <= '0;
            cand_reg <= '0;
            tie_reg  <= 1'b0;
          end else begin
            jogador_atual <= jogador_atual + W_IDX'(1);
          end
        end
        APURA: begin
          max_reg  <= max_n;
          cand_reg <= cand_n;
          tie_reg  <= tie_n;
          k_idx    <= k_idx + W_IDX'(1);
          if (k_idx == ULTIMO) begin
            empate        <= empate_n;
            eliminado_idx <= empate_n ? '0 : cand_n;
            acertou       <= !empate_n && (cand_n == lobo_idx);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/apurador_votos.md
Name: apurador_votos

Overview:
- Sequences the day-vote phase: polls each living player in turn, accepts one vote target per player through a valid handshake, and tallies votes per target.
- After polling, determines the most-voted player.
  - On a unique maximum, reports that player and whether it was the wolf.
  - On a tie or no votes, reports no elimination.
- Sits between the game control unit (drives iniciar from its voting state; consumes votou/acertou) and the vote-input converter/player-state registers.

Parameters:
N_JOGADORES, 5, number of player slots (2..8)
W_IDX, 3, player index width (2**W_IDX >= N_JOGADORES)
W_CNT, 3, per-target vote counter width (2**W_CNT > N_JOGADORES)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; forces OCIOSO and clears all registers
iniciar  input  1  level; high while the control unit is in its voting state
vivos  input  N_JOGADORES  bit i=1 means player i is alive; sampled every cycle
voto_valido  input  1  1-cycle strobe: current voter confirms voto_alvo
voto_alvo  input  W_IDX  target index of the strobed vote
lobo_idx  input  W_IDX  index of the wolf player
jogador_atual  output  W_IDX  index of the player currently voting
aguardando_voto  output  1  high in AGUARDA_VOTO
voto_rejeitado  output  1  1-cycle pulse when a strobed vote is invalid
votou  output  1  high in RESULTADO (tally complete)
acertou  output  1  registered; unique winner == lobo_idx
empate  output  1  registered; tie or zero votes
eliminado_idx  output  W_IDX  registered; unique most-voted index, 0 when empate
db_estado  output  3  current state encoding

Behaviour:
- Reset values: every output 0; db_estado = OCIOSO (0).
- States and encoding:
  - OCIOSO(0): leaves to ZERA when iniciar=1.
  - ZERA(1): clears all counters, jogador_atual, acertou, empate, eliminado_idx. Goes to SELECIONA.
  - SELECIONA(2):
    - If vivos[jogador_atual]=1, goes to AGUARDA_VOTO.
    - Otherwise goes to PROXIMO (dead players are skipped).
  - AGUARDA_VOTO(3): on voto_valido, the vote is valid only if voto_alvo < N_JOGADORES and vivos[voto_alvo]=1.
    - Valid vote: goes to REGISTRA.
    - Invalid vote: pulses voto_rejeitado for 1 cycle and stays.
    - Self-vote is allowed.
  - REGISTRA(4): increments count[voto_alvo_reg]. Goes to PROXIMO.
    - voto_alvo is captured when voto_valido is sampled.
  - PROXIMO(5):
    - If jogador_atual == N_JOGADORES-1: clears the scan index and max registers, then goes to APURA.
    - Otherwise: jogador_atual+1, then goes to SELECIONA.
  - APURA(6): one target per cycle, index k = 0..N_JOGADORES-1.
    - count[k] > max: max=count[k], cand=k, tie=0.
    - count[k] == max and max != 0: tie=1.
    - After k = N_JOGADORES-1, latch the results and go to RESULTADO:
      - empate = tie | (max==0)
      - eliminado_idx = empate ? 0 : cand
      - acertou = !empate & (cand==lobo_idx)
  - RESULTADO(7): votou=1. Goes to OCIOSO when iniciar=0.
- Result registers (acertou, empate, eliminado_idx) hold until the next ZERA. The control unit samples them one cycle after leaving its voting state.
- iniciar falling in any state other than OCIOSO or RESULTADO aborts to OCIOSO. Counters and results are not modified by the abort; the next entry goes through ZERA.
- voto_valido is ignored outside AGUARDA_VOTO.
- vivos changing mid-vote takes effect at the next SELECIONA or validity check. Votes already registered are kept.
- Counters do not saturate; width guarantees no overflow (max N_JOGADORES votes).
- Latency from iniciar=1 to votou=1 with all players voting immediately:
  - 1 (OCIOSO→ZERA) + 1 (ZERA) + per player [SELECIONA + AGUARDA(≥1) + REGISTRA + PROXIMO] + N (APURA).
  - For N=5 with strobes on the first AGUARDA cycle: 2 + 5·4 + 5 = 27 cycles.
- Reset asserted mid-operation returns to OCIOSO immediately with all outputs 0.

Test Plan:
- Unique winner is the wolf: vivos=5'b11111, lobo_idx=2, votes 2,2,0,2,1 → votou=1 after 27 cycles, eliminado_idx=2, acertou=1, empate=0.
- Unique winner is not the wolf: vivos=5'b11111, lobo_idx=4, votes 1,1,1,0,4 → eliminado_idx=1, acertou=0, empate=0.
- Tie and dead skip: vivos=5'b10101, votes 0,4,0 (players 1 and 3 never reach aguardando_voto) → empate=0? No: count0=2, count4=1, so eliminado_idx=0, empate=0.
  - Repeat with votes 0,4,2 → empate=1, acertou=0, eliminado_idx=0.
- Invalid vote: vivos=5'b11101, player 0 strobes voto_alvo=1 (dead) then 6 (out of range) → two voto_rejeitado pulses, state stays 3. Next strobe with 3 is accepted.
- Abort and re-entry: drop iniciar while player 2 is waiting → db_estado=0 next cycle. Re-raise → ZERA clears counts; the full new round's results are independent of the aborted one.
- Async reset in APURA → all outputs 0 without a clock edge. Results stay held in RESULTADO while iniciar=1 and persist after iniciar=0.
